// File: rtl/td4_cpu_core_if.sv
// Fetch and I/O bus between the TD4 core (master) and its ROM/board wrapper (slave).
interface td4_cpu_core_if;
  logic [3:0] addr;
  logic [3:0] opecode;
  logic [3:0] imm;
  logic [3:0] switch;
  logic [3:0] led;

  modport master (
    output addr,
    output led,
    input  opecode,
    input  imm,
    input  switch
  );

  modport slave (
    input  addr,
    input  led,
    output opecode,
    output imm,
    output switch
  );
endinterface

// File: rtl/td4_cpu_core.sv
// TD4-style 4-bit single-cycle accumulator CPU (A, B, carry, PC, output latch).
// Optional macro TD4_UNDEF_HALT_EN: undefined opcodes hold the PC instead of acting as NOPs.
module td4_cpu_core (
  input  logic                  clk,
  input  logic                  n_rst,
  td4_cpu_core_if.master        bus
);

  logic [3:0] a_r, b_r, pc_r, out_r;
  logic       c_r;
  logic [3:0] a_next_s, b_next_s, pc_next_s, out_next_s;
  logic       c_next_s;
  logic [3:0] src_s;
  logic [4:0] sum_s;

  // Opcode bit 2 selects B as the adder source (ADD B,imm), otherwise A.
  assign src_s = bus.opecode[2] ? b_r : a_r;
  assign sum_s = {1'b0, src_s} + {1'b0, bus.imm};

  // Decode and next-state selection; carry is cleared by every non-ADD opcode.
  always_comb begin
    a_next_s   = a_r;
    b_next_s   = b_r;
    out_next_s = out_r;
    pc_next_s  = pc_r + 4'd1;
    c_next_s   = 1'b0;
    case (bus.opecode)
      4'b0000: begin
        a_next_s = sum_s[3:0];
        c_next_s = sum_s[4];
      end
      4'b0001: a_next_s = b_r;
      4'b0010: a_next_s = bus.switch;
      4'b0011: a_next_s = bus.imm;
      4'b0100: b_next_s = a_r;
      4'b0101: begin
        b_next_s = sum_s[3:0];
        c_next_s = sum_s[4];
      end
      4'b0110: b_next_s = bus.switch;
      4'b0111: b_next_s = bus.imm;
      4'b1001: out_next_s = b_r;
      4'b1011: out_next_s = bus.imm;
      4'b1110: begin
        if (!c_r) begin
          pc_next_s = bus.imm;
        end else begin
          pc_next_s = pc_r + 4'd1;
        end
      end
      4'b1111: pc_next_s = bus.imm;
`ifdef TD4_UNDEF_HALT_EN
      4'b1000, 4'b1010, 4'b1100, 4'b1101: pc_next_s = pc_r;
`endif
      default: pc_next_s = pc_r + 4'd1;
    endcase
  end

  // Architectural state register; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_r   <= 4'd0;
      b_r   <= 4'd0;
      pc_r  <= 4'd0;
      out_r <= 4'd0;
      c_r   <= 1'b0;
    end else begin
      a_r   <= a_next_s;
      b_r   <= b_next_s;
      pc_r  <= pc_next_s;
      out_r <= out_next_s;
      c_r   <= c_next_s;
    end
  end

  assign bus.addr = pc_r;
  assign bus.led  = out_r;

endmodule

// File: tb/tb_td4_cpu_core.sv
// Directed bench for td4_cpu_core: an instruction-level model pushes expected addr/led
// into a scoreboard queue as each instruction is driven; entries are popped after the edge.
module tb_td4_cpu_core;

  logic clk;
  logic n_rst;
  td4_cpu_core_if bus ();

  td4_cpu_core dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [3:0] led;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // instruction-level reference state
  logic [3:0] m_a, m_b, m_pc, m_out;
  logic       m_c;

  task automatic model_reset();
    m_a = 4'd0; m_b = 4'd0; m_pc = 4'd0; m_out = 4'd0; m_c = 1'b0;
  endtask

  task automatic model_exec(input logic [3:0] op, input logic [3:0] im, input logic [3:0] sw);
    logic [4:0] s;
    logic [3:0] npc;
    logic       nc;
    npc = m_pc + 4'd1;
    nc  = 1'b0;
    case (op)
      4'h0: begin s = {1'b0, m_a} + {1'b0, im}; m_a = s[3:0]; nc = s[4]; end
      4'h1: m_a = m_b;
      4'h2: m_a = sw;
      4'h3: m_a = im;
      4'h4: m_b = m_a;
      4'h5: begin s = {1'b0, m_b} + {1'b0, im}; m_b = s[3:0]; nc = s[4]; end
      4'h6: m_b = sw;
      4'h7: m_b = im;
      4'h9: m_out = m_b;
      4'hB: m_out = im;
      4'hE: if (m_c == 1'b0) npc = im;
      4'hF: npc = im;
`ifdef TD4_UNDEF_HALT_EN
      4'h8, 4'hA, 4'hC, 4'hD: npc = m_pc;
`endif
      default: ;
    endcase
    m_pc = npc;
    m_c  = nc;
  endtask

  task automatic push_exp();
    exp_t e;
    e.addr = m_pc;
    e.led  = m_out;
    sb_q.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      checks++;
      assert ({bus.addr, bus.led} === {e.addr, e.led})
      else begin
        errors++;
        $error("FAIL %s observed addr=%h led=%h expected addr=%h led=%h",
               tag, bus.addr, bus.led, e.addr, e.led);
      end
    end
  endtask

  // drive one instruction, retire it on the next edge, compare #1 later
  task automatic step(input logic [3:0] op, input logic [3:0] im, input logic [3:0] sw,
                      input string tag);
    bus.opecode = op;
    bus.imm     = im;
    bus.switch  = sw;
    model_exec(op, im, sw);
    push_exp();
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    n_rst       = 1'b0;
    bus.opecode = 4'($urandom_range(0, 15));
    bus.imm     = 4'($urandom_range(0, 15));
    bus.switch  = 4'($urandom_range(0, 15));
    model_reset();
    for (int i = 0; i < 2; i++) begin
      push_exp();
      @(posedge clk);
      #1;
      check("reset_hold");
      bus.opecode = 4'($urandom_range(0, 15));
      bus.imm     = 4'($urandom_range(0, 15));
    end
    n_rst = 1'b1;

    for (int i = 0; i < 16; i++) step(4'h0, 4'h0, 4'h0, "pc_count");

    // I/O path
    step(4'h2, 4'h0, 4'h3, "in_a");
    step(4'h4, 4'h0, 4'h0, "mov_b_a");
    step(4'h9, 4'h0, 4'h0, "out_b_a3");
    step(4'h7, 4'h0, 4'h0, "mov_b_0");
    step(4'h1, 4'h5, 4'h0, "mov_a_b");
    step(4'h4, 4'h0, 4'h0, "mov_b_a");
    step(4'h9, 4'h0, 4'h0, "out_b_a0");
    step(4'h6, 4'h0, 4'h6, "in_b");
    step(4'h9, 4'h0, 4'h0, "out_b_6");
    step(4'h4, 4'h0, 4'h0, "mov_b_a");
    step(4'h9, 4'h0, 4'h0, "out_b_0");
    step(4'hB, 4'hA, 4'h0, "out_imm_a");

    // immediates and ADD
    step(4'h3, 4'h0, 4'h0, "mov_a_0");
    step(4'h3, 4'h1, 4'h0, "mov_a_1");
    step(4'h0, 4'h1, 4'h0, "add_a_1");
    step(4'hE, 4'h4, 4'h0, "jnc_after_nc");
    step(4'h4, 4'h0, 4'h0, "mov_b_a");
    step(4'h9, 4'h0, 4'h0, "out_b_2");
    step(4'h7, 4'h7, 4'h0, "mov_b_7");
    step(4'h5, 4'h1, 4'h0, "add_b_1");
    step(4'h9, 4'h0, 4'h0, "out_b_8");

    // carry and JNC
    step(4'h3, 4'hF, 4'h0, "mov_a_f");
    step(4'h0, 4'h1, 4'h0, "add_a_ovf");
    step(4'hE, 4'h5, 4'h0, "jnc_fall");
    step(4'h4, 4'h0, 4'h0, "mov_b_a");
    step(4'h9, 4'h0, 4'h0, "out_b_wrap");
    step(4'h3, 4'hF, 4'h0, "mov_a_f");
    step(4'h0, 4'h0, 4'h0, "add_a_0");
    step(4'hE, 4'h5, 4'h0, "jnc_take");
    step(4'h7, 4'h9, 4'h0, "mov_b_9");
    step(4'h5, 4'h8, 4'h0, "add_b_ovf");
    step(4'hE, 4'h3, 4'h0, "jnc_fall_b");
    step(4'h9, 4'h0, 4'h0, "out_b_1");

    // JMP, then JNC after JMP (carry cleared)
    step(4'hF, 4'hC, 4'h0, "jmp_c");
    step(4'hE, 4'h2, 4'h0, "jnc_after_jmp");

    // undefined opcode
    for (int i = 0; i < 3; i++) step(4'hA, 4'h7, 4'h0, "undef_1010");
    step(4'h3, 4'h0, 4'h0, "after_undef");

    // async reset between edges
    step(4'hB, 4'h5, 4'h0, "out_imm_5");
    #3;
    n_rst = 1'b0;
    model_reset();
    push_exp();
    #1;
    check("async_reset");
    @(negedge clk);
    n_rst = 1'b1;
    step(4'h0, 4'h0, 4'h0, "resume");
    step(4'h0, 4'h0, 4'h0, "resume");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
